// File: rtl/mux_n1_valid_rr.sv
// mux_n1_valid_rr
// N:1 valid multiplexer with a one-deep registered, back-pressured output stage.
// mode = 0 selects channel `sel`; mode = 1 arbitrates round-robin among valid
// channels starting from rr_ptr. Each output word carries its source channel,
// and completed output transfers are counted with saturation.
module mux_n1_valid_rr #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic [SEL_W-1:0] out_chan,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Output stage and arbitration state
    logic [W-1:0]     r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_chan;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic [SEL_W-1:0] r_rr_ptr;

    // Combinational control
    logic             w_load;
    logic             w_xfer;
    logic             w_fix_found;
    logic [SEL_W-1:0] w_fix_idx;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic [31:0]      w_scan_idx;
    logic             w_grant_v;
    logic [SEL_W-1:0] w_grant;
    logic             w_accept;
    logic [W-1:0]     w_grant_data;

    // The output register can take a new word when empty or when it drains this cycle
    assign w_load = ~r_out_valid | out_ready;
    assign w_xfer = r_out_valid & out_ready;

    // Fixed-select grant; an out-of-range sel simply never matches a channel
    always_comb begin
        w_fix_found = 1'b0;
        w_fix_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if ((32'(sel) == k) && in_valid[k]) begin
                w_fix_found = 1'b1;
                w_fix_idx   = k[SEL_W-1:0];
            end
        end
    end

    // Round-robin grant: first valid channel scanning upward from rr_ptr, wrapping at N
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_scan_idx = (32'(r_rr_ptr) + i) % N;
            if (!w_rr_found && in_valid[w_scan_idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan_idx[SEL_W-1:0];
            end
        end
    end

    // Mode selects which grant source drives the datapath this cycle
    always_comb begin
        w_grant_v = mode ? w_rr_found : w_fix_found;
        w_grant   = mode ? w_rr_idx   : w_fix_idx;
    end

    assign w_accept = w_grant_v & w_load;

    // Ready goes only to the granted channel, and only when the output can load
    always_comb begin
        in_ready = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (w_grant_v && w_load && (32'(w_grant) == k)) begin
                in_ready[k] = 1'b1;
            end
        end
    end

    // Data of the granted channel
    always_comb begin
        w_grant_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(w_grant) == k) begin
                w_grant_data = in_data[k*W +: W];
            end
        end
    end

    // Output register: load on accept, clear valid on a drain without refill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
        end else if (w_accept) begin
            r_out_data  <= w_grant_data;
            r_out_valid <= 1'b1;
            r_out_chan  <= w_grant;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner, only on accepts in round-robin mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept && mode) begin
            if (32'(w_grant) == N - 1) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_grant + 1'b1;
            end
        end
    end

    // Saturating count of completed output transfers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xfer_cnt <= '0;
        end else if (w_xfer && (r_xfer_cnt != '1)) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
